ball_collision_detector: RTL and testbench

BALL_COLLISION_DETECTOR -- requirements
Module: ball_collision_detector

---
 rtl/pong_pkg.sv | 36 +++
 rtl/coll_probe_match.sv | 49 ++++
 rtl/ball_collision_detector.sv | 182 ++++++++++++++++++
 tb/tb_ball_collision_detector.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: collision codes, detector states, probe-hit bundle, geometry defaults.
package pong_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned PROBE_W = 11;
  localparam int unsigned CODE_W  = 4;

  localparam int unsigned BALL_SIZE_DEFAULT = 20;
  localparam int unsigned MISS_Y_DEFAULT    = 530;

  typedef logic [CODE_W-1:0] coll_code_t;

  localparam coll_code_t COLL_LOST        = 4'd0;
  localparam coll_code_t COLL_TOP         = 4'd1;
  localparam coll_code_t COLL_TOP_EDGE    = 4'd2;
  localparam coll_code_t COLL_BOTTOM      = 4'd3;
  localparam coll_code_t COLL_BOTTOM_EDGE = 4'd4;
  localparam coll_code_t COLL_LEFT        = 4'd5;
  localparam coll_code_t COLL_RIGHT       = 4'd6;
  localparam coll_code_t COLL_NONE        = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCAN     = 2'd1,
    ST_REPORT   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_e;

  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } probe_hits_t;

endpackage

// File: rtl/coll_probe_match.sv
// Four probe points around the ball compared against the scan position, with border/paddle masking.
module coll_probe_match
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE = BALL_SIZE_DEFAULT,
  parameter int unsigned PROBE_GAP = 5
) (
  input  logic [COORD_W-1:0] ball_x_i,
  input  logic [COORD_W-1:0] ball_y_i,
  input  logic [COORD_W-1:0] x_pixel_i,
  input  logic [COORD_W-1:0] y_pixel_i,
  input  logic               active_i,
  input  logic               solid_i,
  input  logic               paddle_i,
  input  logic               border_i,
  output probe_hits_t        hits_c_o
);

  localparam int unsigned HALF = BALL_SIZE / 2;
  localparam int unsigned FAR  = BALL_SIZE + PROBE_GAP;

  logic [PROBE_W-1:0] bx, by, px, py;
  logic [PROBE_W-1:0] mid_x, mid_y, top_y, bot_y, left_x, right_x;
  logic               qual;

  // Probes carry an extra bit: underflow wraps into bit 10 and overflow sets it,
  // while the zero-extended scan position never does, so off-screen probes never match.
  assign bx      = PROBE_W'(ball_x_i);
  assign by      = PROBE_W'(ball_y_i);
  assign px      = PROBE_W'(x_pixel_i);
  assign py      = PROBE_W'(y_pixel_i);
  assign mid_x   = bx + PROBE_W'(HALF);
  assign mid_y   = by + PROBE_W'(HALF);
  assign top_y   = by - PROBE_W'(PROBE_GAP);
  assign bot_y   = by + PROBE_W'(FAR);
  assign left_x  = bx - PROBE_W'(PROBE_GAP);
  assign right_x = bx + PROBE_W'(FAR);
  assign qual    = active_i & solid_i;

  // Vertical probes ignore side borders; horizontal probes ignore paddles.
  always_comb begin
    hits_c_o        = '0;
    hits_c_o.top    = qual & ~border_i & (px == mid_x)   & (py == top_y);
    hits_c_o.bottom = qual & ~border_i & (px == mid_x)   & (py == bot_y);
    hits_c_o.left   = qual & ~paddle_i & (px == left_x)  & (py == mid_y);
    hits_c_o.right  = qual & ~paddle_i & (px == right_x) & (py == mid_y);
  end

endmodule

// File: rtl/ball_collision_detector.sv
// Per-frame ball collision detector: records the first probe hit of each frame and
// reports it (or a lost ball) at the next frame start, holding it until acknowledged.
// Optional feature: define BALL_COLL_COOLDOWN_EN to ignore COOLDOWN_FRAMES frames after each ack.
module ball_collision_detector
  import pong_pkg::*;
#(
  parameter int unsigned BALL_SIZE       = BALL_SIZE_DEFAULT,
  parameter int unsigned PROBE_GAP       = 5,
  parameter int unsigned MISS_Y          = MISS_Y_DEFAULT,
  parameter int unsigned COOLDOWN_FRAMES = 2
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic               active,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic               solid,
  input  logic               paddle,
  input  logic               paddle_edge,
  input  logic               border,
  input  logic               coll_ack,
  output logic [CODE_W-1:0]  coll_code,
  output logic               coll_valid
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  coll_code_t         hit_code_q, hit_code_d;
  coll_code_t         code_q, code_d;
  logic               valid_q, valid_d;
  probe_hits_t        hits_c;
  coll_code_t         probe_code_c;
  logic               lost_c;
  logic               report_c;

`ifdef BALL_COLL_COOLDOWN_EN
  localparam int unsigned CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES);
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  logic             cool_last_c;
  assign cool_last_c = (32'(cool_cnt_q) + 32'd1) >= COOLDOWN_FRAMES;
`endif

  coll_probe_match #(
    .BALL_SIZE (BALL_SIZE),
    .PROBE_GAP (PROBE_GAP)
  ) u_probe (
    .ball_x_i  (ball_x_q),
    .ball_y_i  (ball_y_q),
    .x_pixel_i (x_pixel),
    .y_pixel_i (y_pixel),
    .active_i  (active),
    .solid_i   (solid),
    .paddle_i  (paddle),
    .border_i  (border),
    .hits_c_o  (hits_c)
  );

  // Encode the current pixel's probe hit into a collision code.
  always_comb begin
    probe_code_c = COLL_NONE;
    if (hits_c.top)         probe_code_c = paddle_edge ? COLL_TOP_EDGE : COLL_TOP;
    else if (hits_c.bottom) probe_code_c = paddle_edge ? COLL_BOTTOM_EDGE : COLL_BOTTOM;
    else if (hits_c.left)   probe_code_c = COLL_LEFT;
    else if (hits_c.right)  probe_code_c = COLL_RIGHT;
  end

  assign lost_c   = 32'(ball_y_q) > MISS_Y;
  assign report_c = lost_c || (hit_code_q != COLL_NONE);

  // State register.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_SCAN;
      ST_SCAN:   if (frame_start && report_c) state_d = ST_REPORT;
`ifdef BALL_COLL_COOLDOWN_EN
      ST_REPORT: if (coll_ack) state_d = ST_COOLDOWN;
      ST_COOLDOWN: if (frame_start && cool_last_c) state_d = ST_SCAN;
`else
      ST_REPORT: if (coll_ack) state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: ball latch, hit record, reported event.
  always_comb begin
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    hit_code_d = hit_code_q;
    code_d     = code_q;
    valid_d    = valid_q;
`ifdef BALL_COLL_COOLDOWN_EN
    cool_cnt_d = cool_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          ball_x_d   = ball_x;
          ball_y_d   = ball_y;
          hit_code_d = COLL_NONE;
        end
      end
      ST_SCAN: begin
        if (frame_start) begin
          hit_code_d = COLL_NONE;
          if (report_c) begin
            code_d  = lost_c ? COLL_LOST : hit_code_q;
            valid_d = 1'b1;
          end else begin
            ball_x_d = ball_x;
            ball_y_d = ball_y;
            code_d   = COLL_NONE;
          end
        end else if (hit_code_q == COLL_NONE) begin
          hit_code_d = probe_code_c;
        end
      end
      ST_REPORT: begin
        if (coll_ack) begin
          code_d  = COLL_NONE;
          valid_d = 1'b0;
`ifdef BALL_COLL_COOLDOWN_EN
          cool_cnt_d = '0;
`endif
        end
      end
`ifdef BALL_COLL_COOLDOWN_EN
      ST_COOLDOWN: begin
        if (frame_start) begin
          if (cool_last_c) begin
            ball_x_d   = ball_x;
            ball_y_d   = ball_y;
            hit_code_d = COLL_NONE;
          end else begin
            cool_cnt_d = cool_cnt_q + CNT_W'(1);
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      ball_x_q   <= '0;
      ball_y_q   <= '0;
      hit_code_q <= COLL_NONE;
      code_q     <= COLL_NONE;
      valid_q    <= 1'b0;
    end else begin
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      hit_code_q <= hit_code_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

`ifdef BALL_COLL_COOLDOWN_EN
  // Cooldown frame counter.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) cool_cnt_q <= '0;
    else     cool_cnt_q <= cool_cnt_d;
  end
`endif

  assign coll_code  = code_q;
  assign coll_valid = valid_q;

endmodule

// File: tb/tb_ball_collision_detector.sv
// Directed bench for ball_collision_detector: single-hit frame table plus hold/ack/cooldown/reset sequences.
module tb_ball_collision_detector;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] x_pixel = '0, y_pixel = '0;
  logic       active = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0;
  logic       solid = 1'b0, paddle = 1'b0, paddle_edge = 1'b0, border = 1'b0;
  logic       coll_ack = 1'b0;
  logic [3:0] coll_code;
  logic       coll_valid;

  int checks = 0;
  int errors = 0;

  ball_collision_detector dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .frame_start (frame_start),
    .x_pixel     (x_pixel),
    .y_pixel     (y_pixel),
    .active      (active),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .solid       (solid),
    .paddle      (paddle),
    .paddle_edge (paddle_edge),
    .border      (border),
    .coll_ack    (coll_ack),
    .coll_code   (coll_code),
    .coll_valid  (coll_valid)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    string      name;
    logic [9:0] bx, by, sx, sy;
    logic       act, sol, pad, edg, bord;
    logic       ev;
    logic [3:0] ec;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string n, int bx, int by, int sx, int sy,
                              bit act, bit sol, bit pad, bit edg, bit bord,
                              bit ev, int ec);
    vec_t v;
    v.name = n; v.bx = 10'(bx); v.by = 10'(by); v.sx = 10'(sx); v.sy = 10'(sy);
    v.act = act; v.sol = sol; v.pad = pad; v.edg = edg; v.bord = bord;
    v.ev = ev; v.ec = 4'(ec);
    return v;
  endfunction

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic set_idle();
    frame_start = 1'b0; active = 1'b0; solid = 1'b0; paddle = 1'b0;
    paddle_edge = 1'b0; border = 1'b0; coll_ack = 1'b0;
    x_pixel = '0; y_pixel = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic frame_pulse();
    set_idle();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pixel(int x, int y, bit act, bit sol, bit pad, bit edg, bit bord);
    set_idle();
    x_pixel = 10'(x); y_pixel = 10'(y);
    active = act; solid = sol; paddle = pad; paddle_edge = edg; border = bord;
    step();
    set_idle();
  endtask

  task automatic ack_cycle(bit with_fs);
    set_idle();
    coll_ack = 1'b1;
    frame_start = with_fs;
    step();
    set_idle();
  endtask

  task automatic chk(string name, bit ev, logic [3:0] ec);
    checks++;
    if (coll_valid !== ev || coll_code !== ec) begin
      errors++;
      $display("FAIL %s: valid=%0d code=%0d, expected valid=%0d code=%0d",
               name, coll_valid, coll_code, ev, ec);
    end
  endtask

  initial begin
    // name, ball x/y, pixel x/y, active, solid, paddle, edge, border, expected valid/code
    vq.push_back(mk("top",            300, 200, 310, 195, 1, 1, 0, 0, 0, 1, 1));
    vq.push_back(mk("top_edge",       300, 200, 310, 195, 1, 1, 1, 1, 0, 1, 2));
    vq.push_back(mk("bottom",         300, 200, 310, 225, 1, 1, 0, 0, 0, 1, 3));
    vq.push_back(mk("bottom_edge",    300, 438, 310, 463, 1, 1, 1, 1, 0, 1, 4));
    vq.push_back(mk("left",           300, 200, 295, 210, 1, 1, 0, 0, 0, 1, 5));
    vq.push_back(mk("right",          300, 200, 325, 210, 1, 1, 0, 0, 0, 1, 6));
    vq.push_back(mk("right_paddle",   300, 438, 325, 448, 1, 1, 1, 0, 0, 0, 7));
    vq.push_back(mk("top_border",     300, 200, 310, 195, 1, 1, 0, 0, 1, 0, 7));
    vq.push_back(mk("inactive",       300, 200, 310, 195, 0, 1, 0, 0, 0, 0, 7));
    vq.push_back(mk("off_by_one",     300, 200, 311, 195, 1, 1, 0, 0, 0, 0, 7));
    vq.push_back(mk("lost_with_hit",  300, 531, 310, 526, 1, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk("lost_no_hit",    300, 600,   0,   0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(mk("miss_boundary",  300, 530,   0,   0, 0, 0, 0, 0, 0, 0, 7));
    vq.push_back(mk("left_negative",    2, 100,1021, 110, 1, 1, 0, 0, 0, 0, 7));
    vq.push_back(mk("right_overflow",1010, 100,  11, 110, 1, 1, 0, 0, 0, 0, 7));

    apply_reset();
    chk("reset", 0, 7);

    foreach (vq[i]) begin
      apply_reset();
      chk({vq[i].name, "_rst"}, 0, 7);
      ball_x = vq[i].bx; ball_y = vq[i].by;
      frame_pulse();
      chk({vq[i].name, "_start"}, 0, 7);
      pixel(vq[i].sx, vq[i].sy, vq[i].act, vq[i].sol, vq[i].pad, vq[i].edg, vq[i].bord);
      step();
      frame_pulse();
      chk(vq[i].name, vq[i].ev, vq[i].ec);
      ack_cycle(1'b0);
      chk({vq[i].name, "_ack"}, 0, 7);
    end

    // Held report across unacknowledged frames, then ack coinciding with frame_start.
    apply_reset();
    ball_x = 10'd300; ball_y = 10'd200;
    frame_pulse();
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("hold_first", 1, 1);
    for (int f = 0; f < 5; f++) begin
      pixel(310, 225, 1, 1, 0, 0, 0);
      frame_pulse();
      chk($sformatf("hold_frame%0d", f), 1, 1);
    end
    pixel(310, 195, 1, 1, 0, 0, 0);
    ack_cycle(1'b1);
    chk("ack_with_fs", 0, 7);
`ifdef BALL_COLL_COOLDOWN_EN
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("cool_frame1", 0, 7);
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("cool_frame2", 0, 7);
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("cool_frame3_hit", 1, 1);
`else
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("idle_hit_ignored", 0, 7);
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("idle_then_scan_hit", 1, 1);
`endif
    ack_cycle(1'b0);
    chk("hold_ack", 0, 7);

    // First hit in a frame wins.
    apply_reset();
    ball_x = 10'd300; ball_y = 10'd200;
    frame_pulse();
    pixel(295, 210, 1, 1, 0, 0, 0);
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("first_hit_wins", 1, 5);

    // Ball position changes mid-frame; probes keep the latched position.
    apply_reset();
    ball_x = 10'd300; ball_y = 10'd200;
    frame_pulse();
    ball_x = 10'd500; ball_y = 10'd100;
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("latched_ball", 1, 1);

    // Asynchronous reset while a report is pending.
    #3;
    rst = 1'b1;
    #1;
    chk("rst_in_report", 0, 7);
    step();
    rst = 1'b0;
    step();
    ball_x = 10'd300; ball_y = 10'd200;
    frame_pulse();
    ack_cycle(1'b0);
    chk("ack_in_scan", 0, 7);
    pixel(310, 195, 1, 1, 0, 0, 0);
    frame_pulse();
    chk("after_rst_scan", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
